// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and default widths for the Fibonacci sequencer.
package fib_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_IDX_W = 6;
endpackage

// File: rtl/fib_datapath.sv
// fib_datapath: Fibonacci register pair; the overflow flag travels with each term from b into a.
module fib_datapath
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] a_o,
    output logic             ovf_a_o
);
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    logic [WIDTH:0]   sum;
    assign sum = {1'b0, a_q} + {1'b0, b_q};
    always_comb begin
        a_d     = load_i ? '0 : step_i ? b_q : a_q;
        b_d     = load_i ? WIDTH'(1) : step_i ? sum[WIDTH-1:0] : b_q;
        ovf_a_d = load_i ? 1'b0 : step_i ? ovf_b_q : ovf_a_q;
        // once either operand is invalid, every later term is too
        ovf_b_d = load_i ? 1'b0 : step_i ? (ovf_a_q | ovf_b_q | sum[WIDTH]) : ovf_b_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
        end
    end
    assign a_o     = a_q;
    assign ovf_a_o = ovf_a_q;
endmodule

// File: rtl/fib_sequencer.sv
// fib_sequencer: accepts an index n, steps the datapath n times and returns F(n) with overflow.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_value,
    output logic             rsp_overflow,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_value_q, rsp_value_d, a;
    logic             rsp_ovf_q, rsp_ovf_d, ovf_a;
    logic             load, step, finish;
    assign load   = (state_q == IDLE) && req_valid;
    assign finish = (state_q == RUN) && (cnt_q == '0);
    assign step   = (state_q == RUN) && (cnt_q != '0);
    always_comb begin
        state_d     = load ? RUN : finish ? DONE : ((state_q == DONE) && rsp_ready) ? IDLE : state_q;
        cnt_d       = load ? req_n : step ? cnt_q - IDX_W'(1) : cnt_q;
        rsp_value_d = finish ? a : rsp_value_q;
        rsp_ovf_d   = finish ? ovf_a : rsp_ovf_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_value_q <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_value_q <= rsp_value_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end
    fib_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .a_o    (a),
        .ovf_a_o(ovf_a)
    );
    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign rsp_value    = rsp_value_q;
    assign rsp_overflow = rsp_ovf_q;
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: directed and random jobs checked against an arithmetic Fibonacci model.
module tb_fib_sequencer;
    localparam int WIDTH = 32;
    localparam int IDX_W = 6;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [IDX_W-1:0] req_n = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_value;
    logic             rsp_overflow;
    logic             busy;
    int checks = 0;
    int errors = 0;
    fib_sequencer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
        .rsp_overflow(rsp_overflow), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic longint unsigned fib(input int n);
        longint unsigned x = 0, y = 1, t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction
    function automatic logic [WIDTH-1:0] fib_val(input int n);
        longint unsigned f = fib(n);
        return f[WIDTH-1:0];
    endfunction
    function automatic logic fib_ovf(input int n);
        return fib(n) > longint'(32'hFFFF_FFFF);
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // cycle-level model: 0 idle, 1 computing, 2 result held
    int phase = 0, elapsed = 0, model_n = 0;
    bit leave = 0;
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
            leave = 0;
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 1);
        end else begin
            if (phase == 2 && leave) begin
                phase = 0;
                leave = 0;
            end else if (phase == 1) begin
                elapsed++;
                if (elapsed == model_n + 2) phase = 2;
            end
            chk("mon_busy", busy, phase != 0);
            chk("mon_req_ready", req_ready, phase == 0);
            chk("mon_rsp_valid", rsp_valid, phase == 2);
            if (phase == 2) begin
                chk("mon_value", rsp_value, fib_val(model_n));
                chk("mon_overflow", rsp_overflow, fib_ovf(model_n));
            end
            if (phase == 0 && req_valid) begin
                phase = 1;
                elapsed = 0;
                model_n = int'(req_n);
            end else if (phase == 2 && rsp_ready) leave = 1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_job(input int n, input int stall, input logic [63:0] exp_v, input logic exp_o);
        int lat = 0;
        req_n = IDX_W'(n);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk($sformatf("latency_n%0d", n), lat, n + 1);
        if (!rsp_valid) return;
        chk($sformatf("value_n%0d", n), rsp_value, exp_v);
        chk($sformatf("ovf_n%0d", n), rsp_overflow, exp_o);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_n = 6'd3;
            tick();
            chk("stall_req_ready", req_ready, 0);
            chk($sformatf("stall_value_n%0d", n), rsp_value, exp_v);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_job_ready", req_ready, 1);
    endtask
    initial begin
        #1;
        chk("reset_value", rsp_value, 0);
        chk("reset_ovf", rsp_overflow, 0);
        tick();
        rst = 1'b0;
        chk("model_f10", fib(10), 55);
        chk("model_f48", fib(48), 64'd4807526976);
        run_job(0, 0, 0, 0);
        run_job(10, 0, 55, 0);
        run_job(1, 0, 1, 0);
        run_job(2, 0, 1, 0);
        run_job(47, 0, 64'd2971215073, 0);
        run_job(48, 0, 64'd512559680, 1);
        run_job(63, 0, fib_val(63), 1);
        run_job(20, 5, 6765, 0);
        req_n = 6'd30;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_req_ready", req_ready, 1);
        chk("async_value", rsp_value, 0);
        chk("async_ovf", rsp_overflow, 0);
        tick();
        rst = 1'b0;
        tick();
        run_job(5, 0, 5, 0);
        for (int j = 0; j < 30; j++) begin
            int n = int'($urandom_range(47, 0));
            run_job(n, int'($urandom_range(3, 0)), fib_val(n), fib_ovf(n));
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
On-demand Fibonacci engine controller. Accepts a request for index n over a valid/ready handshake and sequences an internal Fibonacci datapath (a <= b, b <= a+b) exactly n steps from a=0, b=1. Returns F(n) with an overflow flag on a valid/ready response channel. Replaces the free-running generator wherever a host needs a specific term rather than a continuous stream.

Parameters:
WIDTH, 32, datapath and result width in bits (unsigned).
IDX_W, 6, width of requested index n (n in 0..2^IDX_W-1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_n  input  IDX_W  requested Fibonacci index.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_value  output  WIDTH  F(n) mod 2^WIDTH.
rsp_overflow  output  1  true F(n) did not fit in WIDTH bits.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, a=0, b=1, cnt=0, ovf_a=0, ovf_b=0, rsp_value=0, rsp_overflow=0, rsp_valid=0, busy=0, req_ready=1 (via IDLE decode).
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On edge with req_valid=1: load a=0, b=1, ovf_a=0, ovf_b=0, cnt=req_n; go RUN. Otherwise hold.
- RUN: req_ready=0. Each edge: if cnt==0, register rsp_value=a, rsp_overflow=ovf_a, go DONE. Otherwise step: a<=b, b<=(a+b) mod 2^WIDTH, cnt<=cnt-1, ovf_a<=ovf_b, ovf_b<=ovf_a|ovf_b|carry_out(a+b).
- Latency: request accepted at edge E0; rsp_valid goes high after edge E(n+1), i.e. n+1 cycles. n=0 gives 1 cycle.
- DONE: rsp_valid=1; rsp_value and rsp_overflow are held stable. On edge with rsp_ready=1, go IDLE and drop rsp_valid. Backpressure is unbounded.
- Addition is WIDTH+1 bits wide internally. The carry marks b as invalid. The overflow flag follows the term into a, so F(n) is flagged only when F(n) itself exceeds 2^WIDTH-1. Overflow of F(n+1) does not set the flag.
- req_valid is ignored outside IDLE. req_n is sampled only on the accepting edge. There is no same-cycle response-accept/request-accept: at least one IDLE cycle separates jobs.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The pending result is lost, and all outputs return to reset values.
- req_n at maximum (2^IDX_W-1) is legal. cnt never wraps because stepping stops at 0.

Decomposition:
- Shared package fib_pkg: state enum (IDLE, RUN, DONE, 2-bit encoding), default WIDTH/IDX_W constants.
- Sub-module fib_datapath: holds a, b, ovf_a, ovf_b. Inputs load and step; outputs a and ovf_a. fib_sequencer holds the FSM, cnt and response registers.

Test Plan:
- Reset, then req_n=0 handshake -> rsp_valid 1 cycle after accept, rsp_value=0, rsp_overflow=0.
- req_n=10 -> rsp_valid exactly 11 cycles after accept, rsp_value=55, overflow=0. Then req_n=1 -> 1, and req_n=2 -> 1.
- WIDTH=32: req_n=47 -> rsp_value=2971215073, overflow=0. req_n=48 -> rsp_value=512559680, overflow=1. req_n=63 -> overflow=1.
- Backpressure: after req_n=20 result, hold rsp_ready=0 for 5 cycles -> rsp_value=6765 stable, req_ready=0 and req_valid ignored throughout. Release -> IDLE next edge, req_ready=1.
- Reset asserted asynchronously mid-RUN (req_n=30, 10 cycles in) -> outputs immediately at reset values. A subsequent req_n=5 returns 5.
- Back-to-back random n in 0..47 with random rsp_ready stalls -> every result matches a reference model and latency is n+1 cycles.
